aes_block_buffer: RTL



---
 rtl/aes_block_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/aes_block_buffer.sv
// rtl/aes_block_buffer.sv - host word packer: key capture plus 128-bit block FIFO for the AES core
// Optional feature macro: BLK_COUNT_EN (adds blk_count output)
module aes_block_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic         wr_en,
    input  logic [31:0]  wr_data,
    input  logic         wr_last,
    output logic         wr_full,
    output logic         overflow,
    output logic         read,
    output logic [127:0] key_out,
    output logic         blk_valid,
    output logic [127:0] blk_data,
    input  logic         blk_ready,
`ifdef BLK_COUNT_EN
    output logic [15:0]  blk_count,
`endif
    output logic         data_done
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_DATA,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [127:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic [95:0]  asm_buf;
    logic [127:0] blk_next;
    logic [1:0]   wcnt;
    logic         fifo_full, fifo_empty;
    logic         accept, push, pop, drop, key_done;

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    always_comb begin
        wr_full = 1'b1;
        case (state)
            S_KEY:   wr_full = 1'b0;
            S_DATA:  wr_full = fifo_full;
            default: wr_full = 1'b1;
        endcase
    end

    assign accept   = enable && wr_en && !wr_full;
    assign drop     = wr_en && wr_full && (state != S_IDLE);
    assign key_done = accept && (state == S_KEY) && (wcnt == 2'd3);
    assign push     = accept && (state == S_DATA) && ((wcnt == 2'd3) || wr_last);
    assign pop      = blk_valid && blk_ready;

    assign blk_valid = !fifo_empty;
    assign blk_data  = fifo_empty ? 128'd0 : mem[rptr[AW-1:0]];
    assign data_done = (state == S_DONE);

    // Current word lands in its slot; slots not yet written read as zero (partial-block padding).
    always_comb begin
        blk_next = 128'd0;
        case (wcnt)
            2'd0: blk_next = {wr_data, 96'd0};
            2'd1: blk_next = {asm_buf[95:64], wr_data, 64'd0};
            2'd2: blk_next = {asm_buf[95:32], wr_data, 32'd0};
            2'd3: blk_next = {asm_buf, wr_data};
            default: blk_next = 128'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  state_nxt = S_KEY;
                S_KEY:   if (key_done) state_nxt = S_DATA;
                S_DATA:  if (accept && wr_last) state_nxt = S_DRAIN;
                S_DRAIN: if (fifo_empty) state_nxt = S_DONE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!n_rst || !enable) begin
            wptr     <= '0;
            rptr     <= '0;
            wcnt     <= 2'd0;
            asm_buf  <= 96'd0;
            overflow <= 1'b0;
            read     <= 1'b0;
            key_out  <= 128'd0;
        end else begin
            read <= key_done;
            if (accept) begin
                case (wcnt)
                    2'd0: asm_buf[95:64] <= wr_data;
                    2'd1: asm_buf[63:32] <= wr_data;
                    2'd2: asm_buf[31:0]  <= wr_data;
                    default: ;
                endcase
                wcnt <= push ? 2'd0 : wcnt + 2'd1;
            end
            if (key_done) key_out <= blk_next;
            if (push)     wptr    <= wptr + 1'b1;
            if (pop)      rptr    <= rptr + 1'b1;
            if (drop)     overflow <= 1'b1;
        end
    end

    // Storage is not reset; blk_data is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= blk_next;
    end

`ifdef BLK_COUNT_EN
    always_ff @(posedge clk) begin
        if (!n_rst || state == S_IDLE) blk_count <= 16'd0;
        else if (pop && blk_count != 16'hFFFF) blk_count <= blk_count + 16'd1;
    end
`endif

endmodule
